// File: rtl/mult_fu_if.sv
// RS-issue / CDB-result bundle for the pipelined multiplier unit.
// master = RS + CDB arbiter side, slave = mult_fu.
interface mult_fu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             squash_flag;
  logic             valid_in;
  logic [TAG_W-1:0] T_in;
  logic [4:0]       dest_reg_in;
  logic [XLEN-1:0]  rs1_value;
  logic [XLEN-1:0]  rs2_value;
  logic [1:0]       mult_func;
  logic             cdb_grant;
  logic             empty;
  logic             done_valid;
  logic [TAG_W-1:0] done_T;
  logic [4:0]       done_dest_reg;
  logic [XLEN-1:0]  done_value;

  modport master (
    output squash_flag, valid_in, T_in, dest_reg_in, rs1_value, rs2_value,
           mult_func, cdb_grant,
    input  empty, done_valid, done_T, done_dest_reg, done_value
  );

  modport slave (
    input  squash_flag, valid_in, T_in, dest_reg_in, rs1_value, rs2_value,
           mult_func, cdb_grant,
    output empty, done_valid, done_T, done_dest_reg, done_value
  );
endinterface

// File: rtl/mult_fu.sv
// Pipelined RV32M MUL/MULH/MULHSU/MULHU unit, one chunk of the multiplier per stage.
// Define MULT_SKID_EN to add a one-entry output skid register (registered empty).
module mult_fu #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int ROBLEN = 32,
  parameter int TAG_W  = $clog2(ROBLEN)
) (
  input logic      clock,
  input logic      reset,
  mult_fu_if.slave bus
);
  localparam int W = 2 * XLEN;
  localparam int C = W / STAGES;
  localparam logic [W-1:0] CHUNK_MASK = {{(W-C){1'b0}}, {C{1'b1}}};

  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0][TAG_W-1:0] r_tag;
  logic [STAGES-1:0][4:0]       r_dest;
  logic [STAGES-2:0][1:0]       r_func;
  logic [STAGES-2:0][W-1:0]     r_acc;
  logic [STAGES-2:0][W-1:0]     r_mc;
  logic [STAGES-2:0][W-1:0]     r_mp;
  logic [XLEN-1:0]              r_res;

  logic [STAGES-1:0][W-1:0]     w_acc_in;
  logic [STAGES-1:0][W-1:0]     w_mc_in;
  logic [STAGES-1:0][W-1:0]     w_mp_in;
  logic [STAGES-1:0][W-1:0]     w_acc_nxt;
  logic [STAGES-1:0][1:0]       w_func_in;
  logic [W-1:0]                 w_ext_rs1;
  logic [W-1:0]                 w_ext_rs2;
  logic                         w_sx1;
  logic                         w_sx2;
  logic                         w_advance;
  logic                         w_empty;
  logic                         w_accept;

  assign w_sx1     = (bus.mult_func == 2'd1) || (bus.mult_func == 2'd2);
  assign w_sx2     = (bus.mult_func == 2'd1);
  assign w_ext_rs1 = {{XLEN{w_sx1 & bus.rs1_value[XLEN-1]}}, bus.rs1_value};
  assign w_ext_rs2 = {{XLEN{w_sx2 & bus.rs2_value[XLEN-1]}}, bus.rs2_value};
  assign w_accept  = bus.valid_in & w_empty & ~bus.squash_flag;

  // The multiplicand shifts left and the multiplier right by C per stage,
  // so every stage multiplies by the low chunk of what it receives.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_in
      assign w_acc_in[s]  = '0;
      assign w_mc_in[s]   = w_ext_rs1;
      assign w_mp_in[s]   = w_ext_rs2;
      assign w_func_in[s] = bus.mult_func;
    end else begin : g_in
      assign w_acc_in[s]  = r_acc[s-1];
      assign w_mc_in[s]   = r_mc[s-1];
      assign w_mp_in[s]   = r_mp[s-1];
      assign w_func_in[s] = r_func[s-1];
    end
    assign w_acc_nxt[s] = w_acc_in[s] + (w_mc_in[s] * (w_mp_in[s] & CHUNK_MASK));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_dest  <= '0;
      r_func  <= '0;
      r_acc   <= '0;
      r_mc    <= '0;
      r_mp    <= '0;
      r_res   <= '0;
    end else if (bus.squash_flag) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid <= {r_valid[STAGES-2:0], w_accept};
      r_tag   <= {r_tag[STAGES-2:0], bus.T_in};
      r_dest  <= {r_dest[STAGES-2:0], bus.dest_reg_in};
      for (int s = 0; s < STAGES - 1; s++) begin
        r_func[s] <= w_func_in[s];
        r_acc[s]  <= w_acc_nxt[s];
        r_mc[s]   <= w_mc_in[s] << C;
        r_mp[s]   <= w_mp_in[s] >> C;
      end
      r_res <= (w_func_in[STAGES-1] == 2'd0) ? w_acc_nxt[STAGES-1][XLEN-1:0]
                                              : w_acc_nxt[STAGES-1][W-1:XLEN];
    end
  end

`ifdef MULT_SKID_EN
  logic             r_skid_full;
  logic [TAG_W-1:0] r_skid_tag;
  logic [4:0]       r_skid_dest;
  logic [XLEN-1:0]  r_skid_val;
  logic             w_skid_load;

  // Skid has priority on the output; an ungranted pipe result parks in skid,
  // and a granted skid entry is refilled by whatever the pipe presents.
  assign w_advance   = ~(r_skid_full & ~bus.cdb_grant);
  assign w_skid_load = r_valid[STAGES-1] & (r_skid_full ? bus.cdb_grant : ~bus.cdb_grant);
  assign w_empty     = ~r_skid_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_skid_full <= 1'b0;
      r_skid_tag  <= '0;
      r_skid_dest <= '0;
      r_skid_val  <= '0;
    end else if (bus.squash_flag) begin
      r_skid_full <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_full <= 1'b1;
      r_skid_tag  <= r_tag[STAGES-1];
      r_skid_dest <= r_dest[STAGES-1];
      r_skid_val  <= r_res;
    end else if (bus.cdb_grant) begin
      r_skid_full <= 1'b0;
    end
  end

  assign bus.done_valid    = r_skid_full | r_valid[STAGES-1];
  assign bus.done_T        = r_skid_full ? r_skid_tag  : r_tag[STAGES-1];
  assign bus.done_dest_reg = r_skid_full ? r_skid_dest : r_dest[STAGES-1];
  assign bus.done_value    = r_skid_full ? r_skid_val  : r_res;
`else
  assign w_advance         = ~(r_valid[STAGES-1] & ~bus.cdb_grant);
  assign w_empty           = w_advance;
  assign bus.done_valid    = r_valid[STAGES-1];
  assign bus.done_T        = r_tag[STAGES-1];
  assign bus.done_dest_reg = r_dest[STAGES-1];
  assign bus.done_value    = r_res;
`endif

  assign bus.empty = w_empty;
endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: vector table, scoreboard monitor and
// hand-written sequences for stall, squash and mid-flight reset.
module tb_mult_fu;
  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_fu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mult_fu #(.XLEN(XLEN), .STAGES(STAGES), .ROBLEN(32), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [4:0]       dest;
    logic [31:0]      val;
  } exp_t;

  typedef struct {
    logic [1:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t e_pop;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    sa  = (f == 2'd1 || f == 2'd2) ? longint'($signed(a)) : longint'({32'b0, a});
    sbv = (f == 2'd1) ? longint'($signed(b)) : longint'({32'b0, b});
    p   = sa * sbv;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input logic v, input logic [TAG_W-1:0] t, input logic [4:0] d,
                       input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] ev);
    bus.valid_in    = v;
    bus.T_in        = t;
    bus.dest_reg_in = d;
    bus.mult_func   = f;
    bus.rs1_value   = a;
    bus.rs2_value   = b;
    if (push) sb.push_back('{t, d, ev});
  endtask

  task automatic cyc_end();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: a result is consumed where done_valid & cdb_grant.
  always @(negedge clock) begin
    if (reset && bus.done_valid && bus.cdb_grant) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e_pop = sb.pop_front();
        chk("sb_tag",  64'(bus.done_T),        64'(e_pop.tag));
        chk("sb_dest", 64'(bus.done_dest_reg), 64'(e_pop.dest));
        chk("sb_val",  64'(bus.done_value),    64'(e_pop.val));
      end
    end
  end

  initial begin
    int lat;
    int cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rf;

    vecs[0]  = '{2'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
    vecs[1]  = '{2'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[2]  = '{2'd2, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[3]  = '{2'd3, 32'hFFFFFFFE, 32'h00000003, 32'h00000002};
    vecs[4]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[6]  = '{2'd3, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[7]  = '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000};
    vecs[8]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[9]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[11] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{2'd2, 32'h00000002, 32'h80000000, 32'h00000001};
    vecs[13] = '{2'd1, 32'h00000002, 32'h80000000, 32'hFFFFFFFF};

    bus.squash_flag = 1'b0;
    bus.cdb_grant   = 1'b1;
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_done_valid", 64'(bus.done_valid), 64'd0);
    chk("rst_empty",      64'(bus.empty),      64'd1);
    chk("rst_done_T",     64'(bus.done_T),     64'd0);
    chk("rst_done_dest",  64'(bus.done_dest_reg), 64'd0);
    chk("rst_done_value", 64'(bus.done_value), 64'd0);
    reset = 1'b1;
    cyc_end();

    // Function table: single issue, latency and tag checked here, value by scoreboard.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, 5'd5, 5'(i), vecs[i].func, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
      cyc_end();
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      lat = 1;
      while (!bus.done_valid && lat < 20) begin
        cyc_end();
        lat++;
      end
      chk("vec_latency", 64'(lat), 64'(STAGES));
      chk("vec_done_T",  64'(bus.done_T), 64'd5);
      cyc_end();
    end

    // Back-to-back, tags 1..4.
    for (int k = 0; k < 9; k++) begin
      if (k < 4) drive(1'b1, 5'(k + 1), 5'(k + 1), 2'd0, 32'(k + 1), 32'd100, 1'b1, 32'((k + 1) * 100));
      else       drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      #1;
      if (k >= 4 && k <= 7) begin
        chk("b2b_valid", 64'(bus.done_valid), 64'd1);
        chk("b2b_tag",   64'(bus.done_T),     64'(k - 3));
      end
      cyc_end();
    end

    // Stall: grant low in cycles 4..6 with two ops in flight.
    for (int k = 0; k < 10; k++) begin
      bus.cdb_grant = !(k >= 4 && k <= 6);
      if (k == 0)      drive(1'b1, 5'd10, 5'd3, 2'd0, 32'd3, 32'd5, 1'b1, 32'd15);
      else if (k == 1) drive(1'b1, 5'd11, 5'd4, 2'd3, 32'hFFFFFFFF, 32'd2, 1'b1, 32'd1);
      else             drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      #1;
      if (k >= 4 && k <= 8) begin
        chk("stall_valid", 64'(bus.done_valid), 64'd1);
        chk("stall_tag",   64'(bus.done_T), (k <= 7) ? 64'd10 : 64'd11);
      end
      if (k >= 4 && k <= 6) begin
        chk("stall_value", 64'(bus.done_value), 64'd15);
`ifdef MULT_SKID_EN
        chk("stall_empty", 64'(bus.empty), (k == 4) ? 64'd1 : 64'd0);
`else
        chk("stall_empty", 64'(bus.empty), 64'd0);
`endif
      end
      cyc_end();
    end
    bus.cdb_grant = 1'b1;

    // Squash in cycle 2 with tags 7,8 in flight and tag 9 offered.
    cnt = 0;
    for (int k = 0; k < 13; k++) begin
      bus.squash_flag = (k == 2);
      if (k < 3) drive(1'b1, 5'(7 + k), 5'd1, 2'd0, 32'd2, 32'd2, 1'b0, '0);
      else       drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      #1;
      if (bus.done_valid) cnt++;
      cyc_end();
    end
    chk("squash_no_done", 64'(cnt), 64'd0);

    // Squash in the cycle a granted result is presented: it counts as consumed.
    for (int k = 0; k < 7; k++) begin
      bus.squash_flag = (k == 4);
      if (k == 0)      drive(1'b1, 5'd20, 5'd6, 2'd0, 32'd9, 32'd9, 1'b1, 32'd81);
      else if (k == 1) drive(1'b1, 5'd21, 5'd6, 2'd0, 32'd9, 32'd8, 1'b0, '0);
      else             drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      #1;
      if (k == 4) chk("sq_grant_tag", 64'(bus.done_T), 64'd20);
      if (k >= 5) chk("sq_after_valid", 64'(bus.done_valid), 64'd0);
      cyc_end();
    end
    bus.squash_flag = 1'b0;

    // Reset mid-flight with three ops in the pipe and the first one stalled at the output.
    bus.cdb_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, 5'(12 + k), 5'd2, 2'd0, 32'd7, 32'd7, 1'b0, '0);
      else       drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      cyc_end();
    end
    chk("pre_rst_valid", 64'(bus.done_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.done_valid), 64'd0);
    chk("mid_rst_empty", 64'(bus.empty),      64'd1);
    chk("mid_rst_T",     64'(bus.done_T),     64'd0);
    chk("mid_rst_value", 64'(bus.done_value), 64'd0);
    cyc_end();
    cyc_end();
    reset = 1'b1;
    bus.cdb_grant = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done_valid) cnt++;
      cyc_end();
    end
    chk("post_rst_stale", 64'(cnt), 64'd0);

    // Random traffic with random grant; issue only when the unit reports empty.
    for (int k = 0; k < 80; k++) begin
      bus.cdb_grant = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.empty && ($urandom_range(0, 3) != 0)) begin
        ra = $urandom();
        rb = $urandom();
        rf = 2'($urandom_range(0, 3));
        drive(1'b1, 5'(k), 5'(k + 3), rf, ra, rb, 1'b1, ref_mul(rf, ra, rb));
      end else begin
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      end
      cyc_end();
    end
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
    bus.cdb_grant = 1'b1;
    lat = 0;
    while (sb.size() != 0 && lat < 30) begin
      cyc_end();
      lat++;
    end
    chk("drain_empty_sb", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
